// File: rtl/qsort_pkg.sv
// Shared types and defaults for the QSort host sequencer.
package qsort_pkg;

  localparam int QS_N        = 8;
  localparam int QS_W        = 32;
  localparam int QS_TIMEOUT  = 1000;
  localparam int INIT_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FEED,
    INIT,
    WAIT,
    UNLOAD,
    EMIT
  } qs_state_t;

endpackage

// File: rtl/qsort_host_buf.sv
// N x W batch buffer: one synchronous write port, one combinational read port.
module qsort_host_buf #(
  parameter int N  = 8,
  parameter int W  = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/qsort_host_seq.sv
// Host sequencer: collect N words, run them through the QSort engine, re-emit sorted.
// Optional sorted-order checker (sort_err port) enabled by defining QSORT_HOST_CHECK_EN.
module qsort_host_seq
  import qsort_pkg::*;
#(
  parameter int N       = QS_N,
  parameter int W       = QS_W,
  parameter int TIMEOUT = QS_TIMEOUT,
  parameter int OUT_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic [W-1:0] q_xin,
  output logic         q_read,
  output logic         q_init,
  output logic         q_write,
  input  logic [W-1:0] q_xout,
  input  logic         q_comp,
  output logic         busy,
  output logic         timeout_err,
`ifdef QSORT_HOST_CHECK_EN
  output logic         sort_err,
`endif
  output qs_state_t    dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(N - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

  // Handshakes: a word moves on a port in any cycle where valid and ready are both
  // high at the rising edge; valid never waits for ready, data is held while stalled.

  qs_state_t     state, state_n;
  logic [CW-1:0] cnt, ccnt;
  logic [TW-1:0] tcnt;
  logic          s_hs, m_hs, cap, wr_dly;
  logic          we;
  logic [CW-1:0] waddr, raddr;
  logic [W-1:0]  wdata, rdata;

  assign s_ready   = (state == IDLE) || (state == LOAD);
  assign s_hs      = s_valid && s_ready;
  assign m_valid   = (state == EMIT);
  assign m_hs      = m_valid && m_ready;
  assign m_data    = m_valid ? rdata : '0;
  assign m_last    = m_valid && (cnt == LAST);
  assign busy      = !((state == IDLE) || (state == LOAD && cnt == '0));
  assign cap       = (state == UNLOAD) && wr_dly;
  assign dbg_state = state;

  // q_write delayed to line up with the sorter's output latency.
  generate
    if (OUT_LAT > 0) begin : g_dly
      logic [OUT_LAT-1:0] sr;
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else        sr <= (sr << 1) | OUT_LAT'(q_write);
      end
      assign wr_dly = sr[OUT_LAT-1];
    end else begin : g_nodly
      assign wr_dly = q_write;
    end
  endgenerate

  qsort_host_buf #(.N(N), .W(W), .AW(CW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Write port is shared by upstream load and sorter capture; the read port
  // prefetches the next FEED word so q_xin can be registered.
  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = s_data;
    raddr = cnt;
    if (s_hs) begin
      we = 1'b1;
    end else if (cap) begin
      we    = 1'b1;
      waddr = ccnt;
      wdata = q_xout;
    end
    if (state == FEED)      raddr = (cnt == LAST) ? '0 : cnt + 1'b1;
    else if (state != EMIT) raddr = '0;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (s_hs) state_n = LOAD;
      LOAD:    if (s_hs && cnt == LAST) state_n = FEED;
      FEED:    if (cnt == LAST) state_n = INIT;
      INIT:    if (cnt == INIT_LAST) state_n = WAIT;
      WAIT: begin
        if (q_comp)               state_n = UNLOAD;
        else if (tcnt == T_LAST)  state_n = IDLE;
      end
      UNLOAD:  if (cap && ccnt == LAST) state_n = EMIT;
      EMIT:    if (m_hs && cnt == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ccnt        <= '0;
      tcnt        <= '0;
      q_read      <= 1'b0;
      q_xin       <= '0;
      q_init      <= 1'b0;
      q_write     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_n;
      q_read  <= (state_n == FEED);
      q_xin   <= (state_n == FEED) ? rdata : '0;
      q_init  <= (state_n == INIT);
      q_write <= (state == WAIT && state_n == UNLOAD) ||
                 (state == UNLOAD && q_write && cnt != LAST);
      tcnt    <= (state == WAIT) ? tcnt + 1'b1 : '0;

      if (state == IDLE && s_hs)               timeout_err <= 1'b0;
      else if (state == WAIT && state_n == IDLE) timeout_err <= 1'b1;

      unique case (state)
        IDLE, LOAD: if (s_hs)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        FEED:                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        INIT:                    cnt <= (cnt == INIT_LAST) ? '0 : cnt + 1'b1;
        UNLOAD:     if (q_write) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        EMIT:       if (m_hs)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        default:                 cnt <= '0;
      endcase

      if (cap) ccnt <= (ccnt == LAST) ? '0 : ccnt + 1'b1;
    end
  end

`ifdef QSORT_HOST_CHECK_EN
  logic [W-1:0] prev_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sort_err  <= 1'b0;
      prev_word <= '0;
    end else begin
      if (state == IDLE && s_hs) sort_err <= 1'b0;
      if (cap) begin
        prev_word <= q_xout;
        if (ccnt != '0 && q_xout < prev_word) sort_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qsort_host_seq.sv
// Directed bench for qsort_host_seq with a behavioural sorter stub.
module tb_qsort_host_seq;
  import qsort_pkg::*;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
  logic [W-1:0] q_xin;
  logic         q_read, q_init, q_write;
  logic [W-1:0] q_xout = '0;
  logic         q_comp = 1'b0;
  logic         busy, timeout_err;
`ifdef QSORT_HOST_CHECK_EN
  logic         sort_err;
`endif
  qs_state_t    dbg_state;

  qsort_host_seq #(.N(N), .W(W), .TIMEOUT(TO), .OUT_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .q_xin(q_xin), .q_read(q_read), .q_init(q_init), .q_write(q_write),
    .q_xout(q_xout), .q_comp(q_comp),
    .busy(busy), .timeout_err(timeout_err),
`ifdef QSORT_HOST_CHECK_EN
    .sort_err(sort_err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sorter stub: returns stub_res, raises q_comp stub_delay cycles after init (<0: never)
  logic [31:0] stub_res [8];
  int          stub_delay = 3;
  int          cd = -1;
  int          xidx = 0;
  logic        wr_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_comp  = 1'b0;
      cd      = -1;
      wr_prev = 1'b0;
      xidx    = 0;
    end else begin
      if (wr_prev && xidx < 8) begin
        q_xout = stub_res[xidx];
        xidx++;
      end
      wr_prev = q_write;
      if (q_write) q_comp = 1'b0;
      if (q_init) begin
        cd   = stub_delay;
        xidx = 0;
      end else if (cd > 0) begin
        cd--;
      end else if (cd == 0) begin
        q_comp = 1'b1;
        cd     = -1;
      end
    end
  end

  // monitors: sorter-side load words and strobe run lengths
  logic [31:0] feed_q [$];
  int          rd_runs [$];
  int          in_runs [$];
  int          rd_run = 0;
  int          in_run = 0;

  always @(negedge clk) begin
    if (q_read) begin
      feed_q.push_back(q_xin);
      rd_run++;
    end else if (rd_run != 0) begin
      rd_runs.push_back(rd_run);
      rd_run = 0;
    end
    if (q_init) in_run++;
    else if (in_run != 0) begin
      in_runs.push_back(in_run);
      in_run = 0;
    end
  end

  task automatic clear_mon();
    feed_q.delete();
    rd_runs.delete();
    in_runs.delete();
  endtask

  task automatic check_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_q_xin", q_xin, 0);
    check("rst_q_read", q_read, 0);
    check("rst_q_init", q_init, 0);
    check("rst_q_write", q_write, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic send_batch(input logic [31:0] v [8], input int gap);
    int k = 0;
    int budget = 0;
    logic acc;
    while (k < 8 && budget < 500) begin
      s_valid = 1'b1;
      s_data  = v[k];
      acc     = s_ready;
      @(negedge clk);
      budget++;
      if (acc) begin
        k++;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    s_valid = 1'b0;
    if (k < 8) check("send_timeout", k, 8);
  endtask

  task automatic recv_batch(input logic [31:0] exp [8], input bit rnd);
    int k = 0;
    int budget = 0;
    while (k < 8 && budget < 2000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid) begin
        check("m_data", m_data, exp[k]);
        check("m_last", m_last, (k == 7));
        if (m_ready) k++;
      end
      @(negedge clk);
      budget++;
    end
    m_ready = 1'b0;
    if (k < 8) check("recv_timeout", k, 8);
    check("end_m_valid", m_valid, 0);
    check("end_s_ready", s_ready, 1);
    check("end_busy", busy, 0);
  endtask

  task automatic run_batch(input logic [31:0] vin [8], input logic [31:0] vout [8],
                           input int gap, input bit rnd, input int dly);
    clear_mon();
    stub_res   = vout;
    stub_delay = dly;
    send_batch(vin, gap);
    check("terr_cleared", timeout_err, 0);
`ifdef QSORT_HOST_CHECK_EN
    check("sort_err_cleared", sort_err, 0);
`endif
    recv_batch(vout, rnd);
    check("rd_runs", rd_runs.size(), 1);
    if (rd_runs.size() == 1) check("rd_len", rd_runs[0], 8);
    check("feed_cnt", feed_q.size(), 8);
    for (int i = 0; i < 8 && i < feed_q.size(); i++) check("q_xin", feed_q[i], vin[i]);
    check("init_runs", in_runs.size(), 1);
    if (in_runs.size() == 1) check("init_len", in_runs[0], 2);
  endtask

  task automatic wait_init(input logic val, input string tag);
    int b = 0;
    while (q_init !== val && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (q_init !== val) check(tag, q_init, val);
  endtask

  task automatic wait_mvalid();
    int b = 0;
    while (!m_valid && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (!m_valid) check("wait_m_valid", m_valid, 1);
  endtask

  logic [31:0] va_in  [8] = '{13, 2, 8, 12, 1, 3, 31, 22};
  logic [31:0] va_out [8] = '{1, 2, 3, 8, 12, 13, 22, 31};
  logic [31:0] vb_in  [8] = '{100, 7, 55, 0, 32'hFFFF_FFFF, 42, 9, 7};
  logic [31:0] vb_out [8] = '{0, 7, 7, 9, 42, 55, 100, 32'hFFFF_FFFF};
`ifdef QSORT_HOST_CHECK_EN
  logic [31:0] vc_out [8] = '{1, 2, 9, 3, 4, 5, 6, 7};
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset();

    // basic batch
    run_batch(va_in, va_out, 0, 1'b0, 3);
    // upstream bubbles, downstream 50% stalls
    run_batch(vb_in, vb_out, 2, 1'b1, 5);
    // q_comp already high when WAIT is entered
    run_batch(va_in, va_out, 0, 1'b1, 0);

    // timeout: q_comp never arrives
    clear_mon();
    stub_delay = -1;
    send_batch(vb_in, 0);
    wait_init(1'b1, "to_init_hi");
    wait_init(1'b0, "to_init_lo");
    repeat (TO - 1) @(negedge clk);
    check("to_before", timeout_err, 0);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_after", timeout_err, 1);
    check("to_s_ready", s_ready, 1);
    check("to_busy_after", busy, 0);
    run_batch(va_in, va_out, 1, 1'b0, 3);

    // reset in the middle of WAIT
    clear_mon();
    stub_delay = -1;
    send_batch(va_in, 0);
    wait_init(1'b1, "rw_init_hi");
    wait_init(1'b0, "rw_init_lo");
    repeat (4) @(negedge clk);
    check("rw_busy", busy, 1);
    pulse_reset();
    check_reset();
    run_batch(vb_in, vb_out, 0, 1'b0, 4);

    // reset in the middle of EMIT
    clear_mon();
    stub_res   = va_out;
    stub_delay = 2;
    send_batch(va_in, 0);
    wait_mvalid();
    for (int i = 0; i < 3; i++) begin
      m_ready = 1'b1;
      check("re_m_data", m_data, va_out[i]);
      @(negedge clk);
    end
    m_ready = 1'b0;
    pulse_reset();
    check_reset();
    run_batch(va_in, va_out, 0, 1'b1, 3);

`ifdef QSORT_HOST_CHECK_EN
    run_batch(va_in, vc_out, 0, 1'b0, 3);
    check("sort_err_set", sort_err, 1);
    run_batch(va_in, va_out, 0, 1'b0, 3);
    check("sort_err_clean", sort_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
